assemble_i_data: RTL

- Input-side counterpart of the FFT output serializer.
- Receives a UART RX byte stream and rebuilds complex samples using the same byte-to-bit mapping the output path uses.
- Presents the samples to the FFT input with a valid/ready handshake.
- Counts samples per frame and flags frame completion, inter-byte timeout and dropped bytes.

---
 rtl/assemble_i_data.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/assemble_i_data.sv
// Rebuilds complex FFT input samples from a UART RX byte stream.
// Optional checksum byte per sample: define ASSEMBLE_I_CHKSUM_EN.
module assemble_i_data #(
  parameter int bit_width   = 28,
  parameter int N_POINT     = 16,
  parameter int TIMEOUT_CYC = 52070
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       ready_i,
  output logic [bit_width-1:0]       data_re_o,
  output logic [bit_width-1:0]       data_im_o,
  output logic                       valid_o,
  output logic [$clog2(N_POINT)-1:0] sample_idx_o,
  output logic                       done_o,
  output logic                       timeout_o,
`ifdef ASSEMBLE_I_CHKSUM_EN
  output logic                       chk_err_o,
`endif
  output logic                       overflow_o
);

  localparam int IW = $clog2(N_POINT);
  localparam int TW = $clog2(TIMEOUT_CYC);
`ifdef ASSEMBLE_I_CHKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] ILAST = IW'(N_POINT - 1);
  localparam logic [2:0]    PLAST = 3'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EMIT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [3:0][7:0]      bytes_q, bytes_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [bit_width-1:0] re_q, re_d;
  logic [bit_width-1:0] im_q, im_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 tout_q, tout_d;
  logic                 ovf_q, ovf_d;
  logic                 chk_q, chk_d;
  logic                 chk_ok;

  // 24-bit word {hi, lo, 8'h00} sign-extended from bit 23
  function automatic logic [bit_width-1:0] ext(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    logic [23:0] w;
    w = {hi, lo, 8'h00};
    return {{(bit_width-23){w[23]}}, w[22:0]};
  endfunction

`ifdef ASSEMBLE_I_CHKSUM_EN
  assign chk_ok = (rx_data ==
    (bytes_q[0] ^ bytes_q[1] ^ bytes_q[2] ^ bytes_q[3]));
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    bytes_d = bytes_q;
    tcnt_d  = tcnt_q;
    idx_d   = idx_q;
    re_d    = re_q;
    im_d    = im_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    tout_d  = 1'b0;
    ovf_d   = ovf_q;
    chk_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        tcnt_d = '0;
        if (rx_valid) begin
          bytes_d[0] = rx_data;
          ptr_d      = 3'd1;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          tcnt_d = '0;
          ptr_d  = ptr_q + 3'd1;
          if (ptr_q < 3'd4)
            bytes_d[ptr_q[1:0]] = rx_data;
          if (ptr_q == PLAST) begin
            ptr_d = '0;
            if (chk_ok) begin
              re_d    = ext(bytes_d[2], bytes_d[0]);
              im_d    = ext(bytes_d[3], bytes_d[1]);
              valid_d = 1'b1;
              state_d = EMIT;
            end else begin
              chk_d   = 1'b1;
              state_d = IDLE;
            end
          end
        end else if (tcnt_q == TLAST) begin
          tcnt_d  = '0;
          ptr_d   = '0;
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      EMIT: begin
        if (rx_valid)
          ovf_d = 1'b1;
        if (ready_i) begin
          valid_d = 1'b0;
          idx_d   = idx_q + 1'b1;
          if (idx_q == ILAST) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        if (rx_valid)
          ovf_d = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      bytes_q <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      bytes_q <= bytes_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      re_q    <= re_d;
      im_q    <= im_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      ovf_q   <= ovf_d;
      chk_q   <= chk_d;
    end
  end

  assign data_re_o    = re_q;
  assign data_im_o    = im_q;
  assign valid_o      = valid_q;
  assign sample_idx_o = idx_q;
  assign done_o       = done_q;
  assign timeout_o    = tout_q;
  assign overflow_o   = ovf_q;
`ifdef ASSEMBLE_I_CHKSUM_EN
  assign chk_err_o    = chk_q;
`else
  logic unused_chk;
  assign unused_chk   = chk_q ^ chk_ok;
`endif

endmodule
